// File: rtl/ex_mem_pipe_if.sv
// EX->MEM stage bus: EX-side request fields, MEM-side head-entry fields,
// flush, forwarding port and stall counter.
interface ex_mem_pipe_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned MEMOP_W = 2,
    parameter int unsigned CNT_W   = 16
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_out;
    logic [ADDR_W-1:0]  in_dst_address;
    logic               in_gpr_we_;
    logic [MEMOP_W-1:0] in_mem_op;
    logic [DATA_W-1:0]  in_mem_wr_data;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  ex_out;
    logic [ADDR_W-1:0]  ex_dst_address;
    logic               ex_gpr_we_;
    logic [MEMOP_W-1:0] ex_mem_op;
    logic [DATA_W-1:0]  ex_mem_wr_data;

    logic               fwd_en;
    logic [ADDR_W-1:0]  fwd_addr;
    logic [DATA_W-1:0]  fwd_data;
    logic [CNT_W-1:0]   stall_cnt;

    // Driver of EX inputs and MEM ready (execute/memory side).
    modport master (
        output flush, in_valid, in_out, in_dst_address, in_gpr_we_,
               in_mem_op, in_mem_wr_data, out_ready,
        input  in_ready, out_valid, ex_out, ex_dst_address, ex_gpr_we_,
               ex_mem_op, ex_mem_wr_data, fwd_en, fwd_addr, fwd_data,
               stall_cnt
    );

    // The pipeline register itself.
    modport slave (
        input  flush, in_valid, in_out, in_dst_address, in_gpr_we_,
               in_mem_op, in_mem_wr_data, out_ready,
        output in_ready, out_valid, ex_out, ex_dst_address, ex_gpr_we_,
               ex_mem_op, ex_mem_wr_data, fwd_en, fwd_addr, fwd_data,
               stall_cnt
    );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with a 2-entry skid buffer (main M + skid S),
// flush, bubble insertion, same-stage forwarding and a saturating stall counter.
module ex_mem_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned MEMOP_W = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    ex_mem_pipe_if.slave       bus
);

    typedef struct packed {
        logic [DATA_W-1:0]  res;
        logic [ADDR_W-1:0]  dst;
        logic               gpr_we_n;
        logic [MEMOP_W-1:0] mem_op;
        logic [DATA_W-1:0]  wr_data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Invalid entries always hold bubble values so outputs need no masking.
    localparam entry_t BUBBLE = '{
        res:      '0,
        dst:      '0,
        gpr_we_n: 1'b1,
        mem_op:   '0,
        wr_data:  '0
    };
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    entry_t           m_q, m_d;
    entry_t           s_q, s_d;
    logic             in_ready_q, in_ready_d;
    logic             fwd_en_q, fwd_en_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    entry_t           in_entry;
    logic             out_valid;
    logic             accept;
    logic             release_head;

    assign in_entry = '{
        res:      bus.in_out,
        dst:      bus.in_dst_address,
        gpr_we_n: bus.in_gpr_we_,
        mem_op:   bus.in_mem_op,
        wr_data:  bus.in_mem_wr_data
    };

    assign out_valid    = (state_q != ST_EMPTY);
    assign accept       = bus.in_valid && in_ready_q;
    assign release_head = out_valid && bus.out_ready;

    // Occupancy next-state, entry movement, ready and forwarding qualifier.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        s_d         = s_q;
        in_ready_d  = in_ready_q;
        fwd_en_d    = 1'b0;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    m_d     = in_entry;
                end
            end
            ST_ONE: begin
                if (accept && release_head) begin
                    m_d = in_entry;
                end else if (accept) begin
                    state_d = ST_FULL;
                    s_d     = in_entry;
                end else if (release_head) begin
                    state_d = ST_EMPTY;
                    m_d     = BUBBLE;
                end
            end
            ST_FULL: begin
                if (release_head) begin
                    state_d = ST_ONE;
                    m_d     = s_q;
                    s_d     = BUBBLE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                m_d     = BUBBLE;
                s_d     = BUBBLE;
            end
        endcase

        if (bus.flush) begin
            state_d = ST_EMPTY;
            m_d     = BUBBLE;
            s_d     = BUBBLE;
        end

        // Ready depends only on next occupancy, never on out_ready directly.
        in_ready_d = (state_d != ST_FULL);
        fwd_en_d   = (state_d != ST_EMPTY) && !m_d.gpr_we_n &&
                     (m_d.mem_op == '0) && (m_d.dst != '0);

        if (out_valid && !bus.out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            m_q         <= BUBBLE;
            s_q         <= BUBBLE;
            in_ready_q  <= 1'b1;
            fwd_en_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            fwd_en_q    <= fwd_en_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid;
    assign bus.ex_out         = m_q.res;
    assign bus.ex_dst_address = m_q.dst;
    assign bus.ex_gpr_we_     = m_q.gpr_we_n;
    assign bus.ex_mem_op      = m_q.mem_op;
    assign bus.ex_mem_wr_data = m_q.wr_data;
    assign bus.fwd_en         = fwd_en_q;
    assign bus.fwd_addr       = m_q.dst;
    assign bus.fwd_data       = m_q.res;
    assign bus.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: reset, streaming, skid/backpressure, flush,
// forwarding, and counter saturation on a second instance with a 4-bit counter.
module tb_ex_mem_pipe;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    ex_mem_pipe_if #(.DATA_W(32), .ADDR_W(5), .MEMOP_W(2), .CNT_W(16)) bus  ();
    ex_mem_pipe_if #(.DATA_W(32), .ADDR_W(5), .MEMOP_W(2), .CNT_W(4))  bus4 ();

    ex_mem_pipe #(.DATA_W(32), .ADDR_W(5), .MEMOP_W(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ex_mem_pipe #(.DATA_W(32), .ADDR_W(5), .MEMOP_W(2), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] dst,
                         input logic we_n, input logic [1:0] op, input logic [31:0] wd);
        bus.in_valid       = v;
        bus.in_out         = d;
        bus.in_dst_address = dst;
        bus.in_gpr_we_     = we_n;
        bus.in_mem_op      = op;
        bus.in_mem_wr_data = wd;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h55, 5'd7, 1'b0, 2'd0, 32'h66);
        bus4.flush = 1'b0;
        bus4.out_ready = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.in_out = 32'h0;
        bus4.in_dst_address = 5'd0;
        bus4.in_gpr_we_ = 1'b1;
        bus4.in_mem_op = 2'd0;
        bus4.in_mem_wr_data = 32'h0;

        // Reset with in_valid held high
        repeat (3) step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_gpr_we_",   32'(bus.ex_gpr_we_), 32'd1);
        chk("rst_ex_out",    bus.ex_out, 32'd0);
        chk("rst_fwd_en",    32'(bus.fwd_en), 32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b1, 2'd0, 32'h0);
        step();
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_in_ready",  32'(bus.in_ready), 32'd1);

        // Streaming 0x10..0x17 with out_ready=1
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 5'(i + 1), 1'b0, 2'd0, 32'h100 + 32'(i));
            step();
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            chk("stream_data",  bus.ex_out, 32'h10 + 32'(i));
            chk("stream_ready", 32'(bus.in_ready), 32'd1);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b1, 2'd0, 32'h0);
        step();
        chk("stream_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("stream_drain_out",   bus.ex_out, 32'd0);
        chk("stream_stall_cnt",   32'(bus.stall_cnt), 32'd0);

        // Skid and backpressure: A then B with MEM stalled
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd5, 1'b0, 2'd0, 32'h0);
        step();
        chk("skid_a_out",   bus.ex_out, 32'hA);
        chk("skid_a_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 32'hB, 5'd6, 1'b0, 2'd0, 32'h0);
        step();
        chk("skid_full_ready", 32'(bus.in_ready), 32'd0);
        chk("skid_full_head",  bus.ex_out, 32'hA);
        chk("skid_stall_1",    32'(bus.stall_cnt), 32'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b1, 2'd0, 32'h0);
        step();
        chk("skid_hold_ready", 32'(bus.in_ready), 32'd0);
        chk("skid_hold_head",  bus.ex_out, 32'hA);
        chk("skid_stall_2",    32'(bus.stall_cnt), 32'd2);
        bus.out_ready = 1'b1;
        step();
        chk("skid_b_out",   bus.ex_out, 32'hB);
        chk("skid_b_valid", 32'(bus.out_valid), 32'd1);
        chk("skid_b_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("skid_empty_valid", 32'(bus.out_valid), 32'd0);
        chk("skid_stall_final", 32'(bus.stall_cnt), 32'd2);

        // Flush in FULL with concurrent in_valid carrying C
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hD, 5'd1, 1'b0, 2'd0, 32'h0);
        step();
        drive(1'b1, 32'hE, 5'd2, 1'b0, 2'd0, 32'h0);
        step();
        chk("flush_pre_ready", 32'(bus.in_ready), 32'd0);
        chk("flush_pre_stall", 32'(bus.stall_cnt), 32'd3);
        bus.flush = 1'b1;
        drive(1'b1, 32'hC, 5'd3, 1'b0, 2'd1, 32'hCC);
        step();
        chk("flush_valid",   32'(bus.out_valid), 32'd0);
        chk("flush_ready",   32'(bus.in_ready), 32'd1);
        chk("flush_gpr_we_", 32'(bus.ex_gpr_we_), 32'd1);
        chk("flush_mem_op",  32'(bus.ex_mem_op), 32'd0);
        chk("flush_out",     bus.ex_out, 32'd0);
        chk("flush_wr_data", bus.ex_mem_wr_data, 32'd0);
        chk("flush_dst",     32'(bus.ex_dst_address), 32'd0);
        chk("flush_stall_kept", 32'(bus.stall_cnt), 32'd4);
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b1, 2'd0, 32'h0);
        bus.out_ready = 1'b1;
        step();
        chk("flush_c_dropped", 32'(bus.out_valid), 32'd0);

        // Flush in ONE drops a concurrent accept
        drive(1'b1, 32'hF, 5'd4, 1'b0, 2'd0, 32'h0);
        step();
        chk("one_f_out", bus.ex_out, 32'hF);
        bus.flush = 1'b1;
        drive(1'b1, 32'hC, 5'd3, 1'b0, 2'd0, 32'h0);
        step();
        chk("one_flush_valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b1, 2'd0, 32'h0);
        step();
        chk("one_flush_c_dropped", 32'(bus.out_valid), 32'd0);

        // Forwarding qualifier
        drive(1'b1, 32'h33, 5'd3, 1'b0, 2'd0, 32'h1234);
        step();
        chk("fwd_dst3_en",   32'(bus.fwd_en), 32'd1);
        chk("fwd_dst3_addr", 32'(bus.fwd_addr), 32'd3);
        chk("fwd_dst3_data", bus.fwd_data, 32'h33);
        chk("fwd_wr_data",   bus.ex_mem_wr_data, 32'h1234);
        drive(1'b1, 32'h44, 5'd0, 1'b0, 2'd0, 32'h0);
        step();
        chk("fwd_r0_en",  32'(bus.fwd_en), 32'd0);
        chk("fwd_r0_out", bus.ex_out, 32'h44);
        drive(1'b1, 32'h55, 5'd4, 1'b0, 2'd1, 32'h0);
        step();
        chk("fwd_load_en", 32'(bus.fwd_en), 32'd0);
        chk("fwd_load_op", 32'(bus.ex_mem_op), 32'd1);
        drive(1'b1, 32'h66, 5'd4, 1'b1, 2'd0, 32'h0);
        step();
        chk("fwd_nowe_en", 32'(bus.fwd_en), 32'd0);
        drive(1'b1, 32'h77, 5'd9, 1'b0, 2'd0, 32'h0);
        step();
        chk("fwd_dst9_en", 32'(bus.fwd_en), 32'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b1, 2'd0, 32'h0);
        step();
        chk("fwd_bubble_en", 32'(bus.fwd_en), 32'd0);

        // Saturation with a 4-bit stall counter
        bus4.in_valid = 1'b1;
        bus4.in_out = 32'h99;
        step();
        bus4.in_valid = 1'b0;
        chk("sat_start", 32'(bus4.stall_cnt), 32'd0);
        repeat (10) step();
        chk("sat_mid", 32'(bus4.stall_cnt), 32'd10);
        repeat (10) step();
        chk("sat_cap", 32'(bus4.stall_cnt), 32'd15);
        chk("sat_head_held", bus4.ex_out, 32'h99);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX→MEM pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, flush support and bubble insertion. It sits between the execute stage and the memory-access stage. It carries the ALU result, destination register, write enable, memory op and store data, and lets a stall from MEM propagate back to EX through a registered `in_ready`. It also drives a same-stage forwarding port and a saturating stall-cycle counter for performance monitoring.

## Interface
- `DATA_W`, default 32, width of ALU result and store data.
- `ADDR_W`, default 5, width of GPR destination address.
- `MEMOP_W`, default 2, width of memory-op code; all-zeros is NOP.
- `CNT_W`, default 16, width of the stall counter.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard all held entries this cycle.
- `in_valid`  in  1  EX presents a valid instruction.
- `in_ready`  out  1  stage can accept; registered.
- `in_out`  in  DATA_W  ALU result.
- `in_dst_address`  in  ADDR_W  destination GPR.
- `in_gpr_we_`  in  1  GPR write enable, active-low.
- `in_mem_op`  in  MEMOP_W  memory operation.
- `in_mem_wr_data`  in  DATA_W  store data.
- `out_valid`  out  1  MEM-side entry valid.
- `out_ready`  in  1  MEM accepts the entry.
- `ex_out`, `ex_dst_address`, `ex_gpr_we_`, `ex_mem_op`, `ex_mem_wr_data`  out  as inputs  head-entry fields.
- `fwd_en`  out  1  head result is forwardable.
- `fwd_addr`  out  ADDR_W  equals `ex_dst_address`.
- `fwd_data`  out  DATA_W  equals `ex_out`.
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles.

## Operation
- Storage: main entry (M) drives the outputs. Skid entry (S) catches one transfer accepted while MEM stalls.
- Accept: `in_valid && in_ready`. Release: `out_valid && out_ready`.
- Occupancy states:
  - EMPTY (M invalid, S invalid).
  - ONE (M valid).
  - FULL (M and S valid).
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + release → ONE, M gets the new entry.
  - ONE + accept, no release → FULL, S gets the new entry.
  - ONE + release only → EMPTY.
  - FULL + release → ONE, S moves to M.
  - FULL never accepts because `in_ready` is 0.
- `in_ready` = next-state ≠ FULL, registered. It is 0 in FULL and 1 otherwise.
- Flush has priority over accept and release. Next state is EMPTY regardless, and any concurrent input is dropped.
- Bubble: when `out_valid`=0, outputs are forced:
  - `ex_gpr_we_`=1 and `ex_mem_op`=0.
  - `ex_out`, `ex_dst_address`, `ex_mem_wr_data` = 0.
- `fwd_en` = `out_valid && !ex_gpr_we_ && ex_mem_op==0 && ex_dst_address!=0`. Loads are not forwardable; r0 is never forwarded.
- `stall_cnt` increments on each cycle with `out_valid && !out_ready`. It saturates at all-ones and is not cleared by flush.
- Field widths are passed through unmodified; there is no arithmetic on the data.

## Timing
- Latency: accept in cycle N → `out_valid` and fields valid in N+1 (EMPTY/ONE path).
- Throughput: 1 per cycle while `out_ready`=1.
- `in_ready` deasserts the cycle after FULL is entered, and reasserts the cycle after the FULL release.
- Flush in cycle N → `out_valid`=0, `in_ready`=1, and bubble outputs from N+1.
- Reset, when `rst`=1 at an edge:
  - Occupancy goes to EMPTY and `stall_cnt` to 0.
  - `in_ready` goes to 1 and all data outputs to 0.
  - `ex_gpr_we_` goes to 1 and `fwd_en` to 0.
- Reset asserted mid-transfer discards M and S; the accept in that cycle is lost.
- No combinational path exists from `out_ready` to `in_ready`.

## Test plan
- Reset check: drive `in_valid`=1 throughout reset → one cycle after reset, `out_valid`=0, `ex_gpr_we_`=1, `in_ready`=1, `stall_cnt`=0.
- Streaming: 8 back-to-back accepts of `in_out`=0x10..0x17 with `out_ready`=1 → outputs 0x10..0x17 on consecutive cycles, one cycle later, no gaps.
- Skid and backpressure:
  - Accept A=0xA, hold `out_ready`=0, accept B=0xB → FULL, `in_ready`=0.
  - Raise `out_ready` → A then B emerge in order, `in_ready` returns to 1.
  - `stall_cnt` equals the stalled cycles.
- Flush in FULL with concurrent `in_valid`=1, C=0xC → next cycle EMPTY, bubble outputs, and C never appears.
- Forwarding, with `in_gpr_we_`=0, `in_mem_op`=0:
  - dst=3 → `fwd_en`=1, `fwd_addr`=3, `fwd_data`=`ex_out`.
  - dst=0 → `fwd_en`=0.
  - `in_mem_op`=1 → `fwd_en`=0.
- Counter saturation, with `CNT_W`=4: hold stall for 20 cycles → `stall_cnt` stops at 15.
